// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command transmitter
// Open-drain drive of ps2c/ps2d with filtered clock edge detection and ack/timeout status.
module ps2_tx #(
  parameter int RTS_CYCLES     = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err
);

  localparam int RW = $clog2(RTS_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RW-1:0] RTS_LOAD  = RW'(RTS_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    filt_q, filt_d;
  logic          fval_q, fval_d;
  logic          fall_edge;
  logic [1:0]    dsync_q;
  logic [8:0]    sh_q, sh_d;
  logic [3:0]    n_q, n_d;
  logic [RW-1:0] rts_q, rts_d;
  logic [TW-1:0] tout_q, tout_d;
  logic          done_q, done_d;
  logic          ack_q, ack_d;
  logic          c_low_q, c_low_d;
  logic          d_low_q, d_low_d;
  logic          timeout;

  assign filt_d = {ps2c, filt_q[7:1]};

  always_comb begin
    fval_d = fval_q;
    if (filt_q == 8'hFF) fval_d = 1'b1;
    else if (filt_q == 8'h00) fval_d = 1'b0;
  end

  assign fall_edge = fval_q & ~fval_d;
  assign timeout   = (tout_q == TOUT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      filt_q  <= 8'hFF;
      fval_q  <= 1'b1;
      dsync_q <= 2'b11;
      sh_q    <= '0;
      n_q     <= '0;
      rts_q   <= '0;
      tout_q  <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      c_low_q <= 1'b0;
      d_low_q <= 1'b0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      fval_q  <= fval_d;
      dsync_q <= {dsync_q[0], ps2d};
      sh_q    <= sh_d;
      n_q     <= n_d;
      rts_q   <= rts_d;
      tout_q  <= tout_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      c_low_q <= c_low_d;
      d_low_q <= d_low_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    n_d     = n_q;
    rts_d   = rts_q;
    tout_d  = tout_q;
    done_d  = 1'b0;
    ack_d   = ack_q;
    case (state_q)
      IDLE: begin
        // done_q blocks a request landing in the completion cycle
        if (wr_ps2 && !done_q) begin
          sh_d    = {~^din, din};
          rts_d   = RTS_LOAD;
          state_d = RTS;
        end
      end
      RTS: begin
        if (rts_q == '0) begin
          tout_d  = '0;
          state_d = START;
        end else begin
          rts_d = rts_q - 1'b1;
        end
      end
      START, DATA, STOP: begin
        tout_d = tout_q + 1'b1;
        if (timeout) begin
          ack_d   = 1'b1;
          done_d  = 1'b1;
          tout_d  = '0;
          state_d = IDLE;
        end else if (fall_edge) begin
          case (state_q)
            START: begin
              n_d     = 4'd8;
              state_d = DATA;
            end
            DATA: begin
              if (n_q == 4'd0) begin
                state_d = STOP;
              end else begin
                sh_d = {1'b0, sh_q[8:1]};
                n_d  = n_q - 1'b1;
              end
            end
            default: begin
              ack_d   = dsync_q[1];
              done_d  = 1'b1;
              tout_d  = '0;
              state_d = IDLE;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line drives are registered from the next state so they only move on clk edges
  always_comb begin
    c_low_d = (state_d == RTS);
    d_low_d = (state_d == START) || ((state_d == DATA) && !sh_d[0]);
  end

  assign ps2c = c_low_q ? 1'b0 : 1'bz;
  assign ps2d = d_low_q ? 1'b0 : 1'bz;

  assign tx_idle      = (state_q == IDLE) && !done_q;
  assign tx_done_tick = done_q;
  assign ack_err      = ack_q;

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 The block SHALL expose parameter RTS_CYCLES, default 12000, clk cycles ps2c is held low for request-to-send (120 us at 100 MHz).
REQ-002 The block SHALL expose parameter TIMEOUT_CYCLES, default 2000000, clk cycles allowed from ps2c release to ack before abort (20 ms at 100 MHz).
REQ-003 The block SHALL have port: clk  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port: wr_ps2  input  1  one-cycle request to send din.
REQ-006 The block SHALL have port: din  input  8  command byte to the device.
REQ-007 The block SHALL have port: ps2c  inout  1  PS/2 clock; driven only to 0, otherwise Z.
REQ-008 The block SHALL have port: ps2d  inout  1  PS/2 data; driven only to 0/bit value, otherwise Z.
REQ-009 The block SHALL have port: tx_idle  output  1  high when no frame in progress; intended to drive ps2_rx rx_en.
REQ-010 The block SHALL have port: tx_done_tick  output  1  one-cycle pulse at frame end (ack, nack or timeout).
REQ-011 The block SHALL have port: ack_err  output  1  status of last frame: 1 = no ack or timeout; held until next frame ends.

Function
REQ-012 The block SHALL filter ps2c through an 8-flop shift register: filtered level goes 1 when all eight samples are 1, 0 when all are 0, else holds.
REQ-013 The block SHALL generate fall_edge as a one-cycle pulse when the filtered ps2c goes 1->0; ps2d SHALL be sampled through a 2-flop synchronizer.
REQ-014 The FSM SHALL have states IDLE, RTS, START, DATA, STOP.
REQ-015 IDLE: both lines Z, tx_idle=1; on wr_ps2 latch shift register {odd_parity(din), din} (parity = XNOR-reduce of din), load RTS counter, go RTS next cycle.
REQ-016 wr_ps2 in any state other than IDLE SHALL be ignored without affecting the frame in progress.
REQ-017 RTS: drive ps2c=0, ps2d Z; after exactly RTS_CYCLES cycles go START.
REQ-018 START: release ps2c, drive ps2d=0 (start bit), clear timeout counter; on fall_edge go DATA with bit counter 8, driving bit 0 (LSB).
REQ-019 DATA: drive ps2d = shift-register LSB; on each fall_edge, if counter 0 go STOP, else shift right and decrement; bits leave LSB first, parity last (edges 2..9 advance, edge 10 exits).
REQ-020 STOP: release ps2d (stop bit 1 by pull-up); on fall_edge (edge 11) set ack_err = synchronized ps2d (0 = ack), pulse tx_done_tick, go IDLE.
REQ-021 The timeout counter SHALL run in START, DATA, STOP; on reaching TIMEOUT_CYCLES: release both lines, ack_err=1, pulse tx_done_tick, go IDLE, take priority over a same-cycle fall_edge.
REQ-022 Line drive changes SHALL occur only on clk edges; no combinational path from wr_ps2 to ps2c/ps2d.
REQ-023 tx_idle SHALL be 0 from the cycle after accepted wr_ps2 until the cycle after tx_done_tick.
REQ-024 A new wr_ps2 in the same cycle tx_done_tick is high SHALL be ignored; it is accepted from the next cycle.

Reset
REQ-025 While reset=0, state SHALL be IDLE, ps2c/ps2d Z, tx_idle=1, tx_done_tick=0, ack_err=0, counters 0, filter all ones, asynchronously, including mid-frame.
REQ-026 After reset release no spurious fall_edge SHALL occur while ps2c idles high.

Verification
REQ-027 Reset pulse mid-DATA -> lines Z and tx_idle=1 in same cycle as reset falls, no tx_done_tick.
REQ-028 wr_ps2 with din=0xF4, device model clocks at 10 kHz and acks -> ps2c low exactly 12000 cycles, model samples bits 0,0,1,0,1,1,1,1, parity 0, stop 1; one tx_done_tick, ack_err=0.
REQ-029 din=0xED, model holds ps2d high at edge 11 -> parity observed 1, tx_done_tick, ack_err=1.
REQ-030 TIMEOUT_CYCLES=5000, model never clocks -> exactly 5000 cycles after START entry: lines Z, tx_done_tick, ack_err=1, tx_idle=1 next cycle.
REQ-031 Second wr_ps2 (din=0x00) during DATA of 0xF4 frame -> ignored; model still receives 0xF4.
REQ-032 5-cycle low glitch on ps2c during DATA -> no bit advance; frame completes correctly.
